// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC multi-cycle controller: opcodes, ALU codes,
// instruction field positions, FSM states and the decoded-instruction record.
package kgp_pkg;
    localparam logic [5:0] OP_RALU  = 6'h00;
    localparam logic [5:0] OP_IALU  = 6'h01;
    localparam logic [5:0] OP_SHIFT = 6'h02;
    localparam logic [5:0] OP_LD    = 6'h03;
    localparam logic [5:0] OP_ST    = 6'h04;
    localparam logic [5:0] OP_BR    = 6'h08;
    localparam logic [5:0] OP_B     = 6'h09;
    localparam logic [5:0] OP_BZ    = 6'h0A;
    localparam logic [5:0] OP_BNZ   = 6'h0B;
    localparam logic [5:0] OP_BCY   = 6'h0C;
    localparam logic [5:0] OP_BNCY  = 6'h0D;
    localparam logic [5:0] OP_BS    = 6'h0E;
    localparam logic [5:0] OP_BNS   = 6'h0F;
    localparam logic [5:0] OP_CALL  = 6'h10;
    localparam logic [5:0] OP_RET   = 6'h11;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SLA = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;

    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int SH_LSB = 11;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_SHIFT, C_LD, C_ST, C_BR, C_BRANCH, C_CALL, C_RET, C_HALT
    } cls_t;

    typedef struct packed {
        cls_t        cls;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        const_src;
        logic        reg_data;
        logic        wsel;
        logic        mul;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  shamt;
        logic [20:0] imm;
    } dec_t;

    function automatic logic br_taken(input logic [5:0] op, input logic z, input logic c,
                                      input logic s);
        case (op)
            OP_B:    br_taken = 1'b1;
            OP_BZ:   br_taken = z;
            OP_BNZ:  br_taken = !z;
            OP_BCY:  br_taken = c;
            OP_BNCY: br_taken = !c;
            OP_BS:   br_taken = s;
            OP_BNS:  br_taken = !s;
            default: br_taken = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/kgp_decode.sv
// Combinational instruction decode: IR to instruction class and static datapath controls.
module kgp_decode
    import kgp_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);
    logic [5:0] op;
    assign op = ir[OP_LSB +: 6];

    always_comb begin
        dec       = '0;
        dec.cls   = C_HALT;
        dec.ra1   = ir[RS_LSB +: 5];
        dec.ra2   = ir[RT_LSB +: 5];
        case (op)
            OP_RALU: begin
                dec.cls      = C_RALU;
                dec.alu_op   = ir[3:0];
                dec.reg_data = 1'b1;
                dec.mul      = (ir[3:0] == ALU_MUL);
            end
            // imm21 overlaps the funct bits, so the immediate form is always an add
            OP_IALU: begin
                dec.cls      = C_IALU;
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.imm      = ir[20:0];
                dec.reg_data = 1'b1;
            end
            OP_SHIFT: begin
                dec.cls       = C_SHIFT;
                dec.alu_op    = ir[3:0];
                dec.alu_src   = 1'b1;
                dec.const_src = 1'b1;
                dec.shamt     = ir[SH_LSB +: 5];
                dec.reg_data  = 1'b1;
            end
            OP_LD, OP_ST: begin
                dec.cls     = (op == OP_LD) ? C_LD : C_ST;
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.imm     = {{5{ir[15]}}, ir[15:0]};
                dec.wsel    = (op == OP_LD);
            end
            OP_BR: begin
                dec.cls     = C_BR;
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
            end
            OP_B, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BS, OP_BNS: dec.cls = C_BRANCH;
            OP_CALL: dec.cls = C_CALL;
            OP_RET: begin
                dec.cls     = C_RET;
                dec.ra1     = 5'd31;
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
            end
            default: dec.cls = C_HALT;
        endcase
    end
endmodule

// File: rtl/kgp_multicycle_control.sv
// KGP-RISC multi-cycle sequencer: fetch handshake, FSM, PC and flag register, with
// all datapath controls registered from the next state and next IR.
module kgp_multicycle_control
    import kgp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        sign_flag,
    input  logic        overflow_flag,
    input  logic [31:0] alu_result,
    output logic        regWriteEnable,
    output logic        regWrite_select,
    output logic        reg_to_pc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALU_src,
    output logic        const_src,
    output logic        reg_data,
    output logic        mult_flag,
    output logic [4:0]  regAddr_1,
    output logic [4:0]  regAddr_2,
    output logic [4:0]  shift_amount,
    output logic [3:0]  alu_control,
    output logic [20:0] immediate_const,
    output logic [31:0] npc,
    output logic [31:0] pc,
    output logic        halted
);
    state_t      state, ns;
    logic [31:0] ir, ir_d, jr_tgt, br_tgt, pc_nx;
    logic [3:0]  flg;
    dec_t        dec;
    logic        act, wb_wr, alu_cls, unused_ovf;

    // Decoding the incoming word lets DECODE-state controls come straight out of a flop.
    assign ir_d = (state == S_FETCH && imem_ready) ? imem_rdata : ir;
    kgp_decode u_dec (.ir(ir_d), .dec(dec));

    assign npc        = pc + 32'd4;
    assign imem_addr  = pc;
    assign br_tgt     = npc + {{4{ir[25]}}, ir[25:0], 2'b00};
    assign act        = ns inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK};
    assign wb_wr      = dec.cls inside {C_RALU, C_IALU, C_SHIFT, C_LD, C_CALL};
    assign alu_cls    = dec.cls inside {C_RALU, C_IALU, C_SHIFT};
    assign unused_ovf = flg[0];

    always_comb begin
        ns    = state;
        pc_nx = pc;
        case (state)
            S_FETCH:   if (imem_ready) ns = S_DECODE;
            S_DECODE:  ns = (dec.cls == C_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (dec.cls inside {C_LD, C_ST}) ns = S_MEM;
                else if (dec.cls == C_BRANCH) begin
                    ns    = S_FETCH;
                    pc_nx = br_taken(ir[OP_LSB +: 6], flg[3], flg[2], flg[1]) ? br_tgt : npc;
                end else ns = S_WRITEBACK;
            end
            S_MEM: begin
                if (dec.cls == C_LD) ns = S_WRITEBACK;
                else begin
                    ns    = S_FETCH;
                    pc_nx = npc;
                end
            end
            S_WRITEBACK: begin
                ns = S_FETCH;
                case (dec.cls)
                    C_CALL:      pc_nx = br_tgt;
                    C_BR, C_RET: pc_nx = jr_tgt;
                    default:     pc_nx = npc;
                endcase
            end
            S_HALT:  ns = S_HALT;
            default: ns = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FETCH;
            pc              <= RESET_PC;
            ir              <= '0;
            flg             <= '0;
            jr_tgt          <= '0;
            imem_req        <= 1'b1;
            halted          <= 1'b0;
            regWriteEnable  <= 1'b0;
            regWrite_select <= 1'b0;
            reg_to_pc       <= 1'b0;
            MemRead         <= 1'b0;
            MemWrite        <= 1'b0;
            ALU_src         <= 1'b0;
            const_src       <= 1'b0;
            reg_data        <= 1'b0;
            mult_flag       <= 1'b0;
            regAddr_1       <= '0;
            regAddr_2       <= '0;
            shift_amount    <= '0;
            alu_control     <= '0;
            immediate_const <= '0;
        end else begin
            state <= ns;
            pc    <= pc_nx;
            if (state == S_FETCH && imem_ready) ir <= imem_rdata;
            if (state == S_EXECUTE) begin
                jr_tgt <= alu_result;
                if (alu_cls) flg <= {zero_flag, carry_flag, sign_flag, overflow_flag};
            end
            imem_req        <= (ns == S_FETCH);
            halted          <= (ns == S_HALT);
            regWriteEnable  <= (ns == S_WRITEBACK) && wb_wr;
            reg_to_pc       <= (ns == S_WRITEBACK) && (dec.cls == C_CALL);
            mult_flag       <= (ns == S_WRITEBACK) && dec.mul;
            MemRead         <= (ns == S_MEM) && (dec.cls == C_LD);
            MemWrite        <= (ns == S_MEM) && (dec.cls == C_ST);
            ALU_src         <= act && dec.alu_src;
            const_src       <= act && dec.const_src;
            reg_data        <= act && dec.reg_data;
            regWrite_select <= act && dec.wsel;
            regAddr_1       <= act ? dec.ra1    : '0;
            regAddr_2       <= act ? dec.ra2    : '0;
            shift_amount    <= act ? dec.shamt  : '0;
            alu_control     <= act ? dec.alu_op : '0;
            immediate_const <= act ? dec.imm    : '0;
        end
    end
endmodule

// File: tb/tb_kgp_multicycle_control.sv
// Directed bench for kgp_multicycle_control: fetch handshake, ALU, branch, load,
// call/return, mid-instruction reset and halt.
module tb_kgp_multicycle_control;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        zero_flag = 1'b0, carry_flag = 1'b0, sign_flag = 1'b0, overflow_flag = 1'b0;
    logic [31:0] alu_result = '0;
    logic        regWriteEnable, regWrite_select, reg_to_pc, MemRead, MemWrite;
    logic        ALU_src, const_src, reg_data, mult_flag, halted;
    logic [4:0]  regAddr_1, regAddr_2, shift_amount;
    logic [3:0]  alu_control;
    logic [20:0] immediate_const;
    logic [31:0] npc, pc;
    int checks = 0, errors = 0;

    kgp_multicycle_control #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .sign_flag(sign_flag), .overflow_flag(overflow_flag),
        .alu_result(alu_result), .regWriteEnable(regWriteEnable),
        .regWrite_select(regWrite_select), .reg_to_pc(reg_to_pc), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALU_src(ALU_src), .const_src(const_src), .reg_data(reg_data),
        .mult_flag(mult_flag), .regAddr_1(regAddr_1), .regAddr_2(regAddr_2),
        .shift_amount(shift_amount), .alu_control(alu_control),
        .immediate_const(immediate_const), .npc(npc), .pc(pc), .halted(halted));

    always #5 clk = ~clk;

    // Inputs change and outputs are observed on the falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fetch_instr(input logic [31:0] w, input int dly, output int req_cnt);
        req_cnt = 0;
        for (int i = 0; i < dly; i++) begin
            imem_ready = 1'b0;
            if (imem_req) req_cnt++;
            @(negedge clk);
        end
        imem_ready = 1'b1; imem_rdata = w;
        if (imem_req) req_cnt++;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0C65FFFC;
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (npc !== 32'h4) begin errors++; $display("FAIL rst_npc got=%h exp=%h", npc, 32'h4); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got=%b exp=1", imem_req); end
        checks++; if ({halted, regWriteEnable, MemRead, MemWrite, ALU_src, reg_data, reg_to_pc} !== 7'b0)
            begin errors++; $display("FAIL rst_ctrl got=%b exp=0", {halted, regWriteEnable, MemRead, MemWrite, ALU_src, reg_data, reg_to_pc}); end
        checks++; if ({regAddr_1, regAddr_2, alu_control, immediate_const} !== 35'b0)
            begin errors++; $display("FAIL rst_fields got=%h exp=0", {regAddr_1, regAddr_2, alu_control, immediate_const}); end
    endtask

    task automatic test_alu_add();
        int rc, we;
        fetch_instr(32'h00220000, 2, rc);
        checks++; if (rc !== 3) begin errors++; $display("FAIL add_req_cycles got=%0d exp=3", rc); end
        checks++; if (regAddr_1 !== 5'd1 || regAddr_2 !== 5'd2) begin errors++; $display("FAIL add_regs got=%0d,%0d exp=1,2", regAddr_1, regAddr_2); end
        checks++; if ({imem_req, reg_data, ALU_src} !== 3'b010) begin errors++; $display("FAIL add_dec_ctrl got=%b exp=010", {imem_req, reg_data, ALU_src}); end
        we = 0;
        for (int i = 0; i < 3; i++) begin
            if (regWriteEnable) we++;
            @(negedge clk);
        end
        checks++; if (we !== 1) begin errors++; $display("FAIL add_we_pulse got=%0d exp=1", we); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL add_pc got=%h exp=%h", pc, 32'h4); end
        checks++; if (imem_req !== 1'b1 || regWriteEnable !== 1'b0) begin errors++; $display("FAIL add_back_fetch got=%b%b exp=10", imem_req, regWriteEnable); end
    endtask

    task automatic test_branch();
        int rc, side;
        do_reset();
        fetch_instr(32'h00210001, 0, rc);     // SUB r1,r1
        @(negedge clk);
        zero_flag = 1'b1;
        @(negedge clk);
        zero_flag = 1'b0;                     // branch must use the latched copy
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL sub_pc got=%h exp=%h", pc, 32'h4); end
        fetch_instr(32'h28000003, 0, rc);     // BZ +3
        side = 0;
        for (int i = 0; i < 2; i++) begin
            if (regWriteEnable || MemRead || MemWrite) side++;
            @(negedge clk);
        end
        checks++; if (pc !== 32'd20) begin errors++; $display("FAIL bz_pc got=%h exp=%h", pc, 32'd20); end
        checks++; if (side !== 0) begin errors++; $display("FAIL bz_side got=%0d exp=0", side); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bz_3cyc got=%b exp=1", imem_req); end
        fetch_instr(32'h2C000005, 0, rc);     // BNZ +5, not taken
        @(negedge clk); @(negedge clk);
        checks++; if (pc !== 32'd24) begin errors++; $display("FAIL bnz_pc got=%h exp=%h", pc, 32'd24); end
    endtask

    task automatic test_load();
        int rc;
        do_reset();
        fetch_instr(32'h0C65FFFC, 0, rc);     // LD r5, -4(r3)
        checks++; if (immediate_const !== 21'h1FFFFC) begin errors++; $display("FAIL ld_imm got=%h exp=%h", immediate_const, 21'h1FFFFC); end
        checks++; if (regAddr_1 !== 5'd3 || regAddr_2 !== 5'd5) begin errors++; $display("FAIL ld_regs got=%0d,%0d exp=3,5", regAddr_1, regAddr_2); end
        checks++; if ({ALU_src, const_src, MemRead} !== 3'b100) begin errors++; $display("FAIL ld_dec got=%b exp=100", {ALU_src, const_src, MemRead}); end
        @(negedge clk);
        checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL ld_ex_rd got=%b exp=0", MemRead); end
        @(negedge clk);
        checks++; if ({MemRead, MemWrite, regWriteEnable} !== 3'b100) begin errors++; $display("FAIL ld_mem got=%b exp=100", {MemRead, MemWrite, regWriteEnable}); end
        @(negedge clk);
        checks++; if ({MemRead, regWriteEnable, reg_data, regWrite_select} !== 4'b0101)
            begin errors++; $display("FAIL ld_wb got=%b exp=0101", {MemRead, regWriteEnable, reg_data, regWrite_select}); end
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ld_pc got=%h exp=%h", pc, 32'h4); end
    endtask

    task automatic test_call_ret();
        int rc;
        do_reset();
        fetch_instr(32'h2400000F, 0, rc);     // B +15 -> 0x40
        @(negedge clk); @(negedge clk);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL b_pc got=%h exp=%h", pc, 32'h40); end
        fetch_instr(32'h40000004, 0, rc);     // CALL +4
        @(negedge clk); @(negedge clk);
        checks++; if ({reg_to_pc, regWriteEnable} !== 2'b11 || npc !== 32'h44)
            begin errors++; $display("FAIL call_wb got=%b%b npc=%h exp=11 npc=44", reg_to_pc, regWriteEnable, npc); end
        @(negedge clk);
        checks++; if (pc !== 32'h54) begin errors++; $display("FAIL call_pc got=%h exp=%h", pc, 32'h54); end
        fetch_instr(32'h44000000, 0, rc);     // RET
        checks++; if (regAddr_1 !== 5'd31 || immediate_const !== 21'h0 || ALU_src !== 1'b1 || alu_control !== 4'd0)
            begin errors++; $display("FAIL ret_dec got=%0d,%h,%b,%h exp=31,0,1,0", regAddr_1, immediate_const, ALU_src, alu_control); end
        @(negedge clk);
        alu_result = 32'h44;
        @(negedge clk);
        alu_result = 32'h0;
        checks++; if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL ret_we got=%b exp=0", regWriteEnable); end
        @(negedge clk);
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL ret_pc got=%h exp=%h", pc, 32'h44); end
    endtask

    task automatic test_reset_mid();
        int rc;
        do_reset();
        fetch_instr(32'h00220000, 0, rc);     // ADD sets zero flag
        @(negedge clk);
        zero_flag = 1'b1;
        @(negedge clk);
        zero_flag = 1'b0;
        @(negedge clk);
        fetch_instr(32'h10650008, 0, rc);     // ST
        @(negedge clk); @(negedge clk);
        checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL st_mem got=%b exp=1", MemWrite); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({MemWrite, regWriteEnable} !== 2'b00 || pc !== 32'h0)
            begin errors++; $display("FAIL st_abort got=%b%b pc=%h exp=00 pc=0", MemWrite, regWriteEnable, pc); end
        fetch_instr(32'h28000003, 0, rc);     // BZ must see cleared flags
        @(negedge clk); @(negedge clk);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL flag_clear_pc got=%h exp=%h", pc, 32'h4); end
    endtask

    task automatic test_halt();
        int rc, req;
        do_reset();
        fetch_instr(32'hA8000000, 0, rc);     // opcode 2A
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_dec got=%b exp=0", halted); end
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
        req = 0;
        imem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req || !halted) req++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        checks++; if (req !== 0 || pc !== 32'h0) begin errors++; $display("FAIL halt_hold got=%0d pc=%h exp=0 pc=0", req, pc); end
        do_reset();
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL halt_exit got=%b%b exp=01", halted, imem_req); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alu_add();
        test_branch();
        test_load();
        test_call_ret();
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
